snake_body_writer: RTL and testbench



---
 rtl/snake_body_writer_pkg.sv | 9 +
 rtl/snake_body_writer_collision_scanner.sv | 28 ++
 rtl/snake_body_writer.sv | 149 ++++++++++++++
 tb/tb_snake_body_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_body_writer_pkg.sv
// snake_body_writer_pkg: shared heading and FSM encodings for the snake body writer
// Exports dir_e (up/right/down/left), state_e (IDLE/SHIFT/SCAN/DEAD) and opposite().
package snake_body_writer_pkg;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_e;
  typedef enum logic [1:0] {IDLE, SHIFT, SCAN, DEAD} state_e;
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction
endpackage

// File: rtl/snake_body_writer_collision_scanner.sv
// snake_collision_scanner: walks body slots one per cycle and compares each against the head
// Ports: clk, reset (async active-low), start (load idx=1), run (scan active), length,
// head_x/head_y, slot_x/slot_y (table entry at idx), idx, hit, done.
module snake_collision_scanner #(
  parameter int COORD_W = 32,
  parameter int LEN_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               run,
  input  logic [LEN_W-1:0]   length,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] slot_x,
  input  logic [COORD_W-1:0] slot_y,
  output logic [LEN_W-1:0]   idx,
  output logic               hit,
  output logic               done
);
  assign hit = run && slot_x == head_x && slot_y == head_y;
  assign done = run && idx == length - 1'b1;
  // idx holds on the last slot so it never points past the table
  always_ff @(posedge clk or negedge reset)
    if (!reset) idx <= LEN_W'(1);
    else if (start) idx <= LEN_W'(1);
    else if (run && !done) idx <= idx + 1'b1;
endmodule

// File: rtl/snake_body_writer.sv
// snake_body_writer: owns the snake segment table, moves/grows it per game tick, flags wall/self hits
// Ports: clk, reset (async active-low), step (tick pulse), dir (0 up,1 right,2 down,3 left), grow,
// restart (sync reload), x_values/y_values (packed slots, -1 when unused), length, busy, moved, game_done.
module snake_body_writer
  import snake_body_writer_pkg::*;
#(
  parameter int MAX_LEN = 100,
  parameter int COORD_W = 32,
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int INIT_LEN = 3,
  parameter int START_X = 5,
  parameter int START_Y = 5,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic [1:0]                 dir,
  input  logic                       grow,
  input  logic                       restart,
  output logic [MAX_LEN*COORD_W-1:0] x_values,
  output logic [MAX_LEN*COORD_W-1:0] y_values,
  output logic [LEN_W-1:0]           length,
  output logic                       busy,
  output logic                       moved,
  output logic                       game_done
);
  typedef logic signed [COORD_W-1:0] coord_t;
  localparam coord_t GX = coord_t'(GRID_W);
  localparam coord_t GY = coord_t'(GRID_H);
  coord_t xs [MAX_LEN];
  coord_t ys [MAX_LEN];
  coord_t cand_x, cand_y, nx, ny;
  dir_e heading, eff;
  state_e state, state_d;
  logic grow_q, latch, do_shift, scan_start, busy_d, moved_d, done_d, wall, hit, done;
  logic [LEN_W-1:0] idx;

  function automatic coord_t init_x(input int i);
    return i < INIT_LEN ? coord_t'(START_X - i) : '1;
  endfunction
  function automatic coord_t init_y(input int i);
    return i < INIT_LEN ? coord_t'(START_Y) : '1;
  endfunction

  // a reversal request keeps the current heading
  assign eff = opposite(heading) == dir_e'(dir) ? heading : dir_e'(dir);
  assign nx = eff == DIR_RIGHT ? xs[0] + 1'b1 : eff == DIR_LEFT ? xs[0] - 1'b1 : xs[0];
  assign ny = eff == DIR_DOWN ? ys[0] + 1'b1 : eff == DIR_UP ? ys[0] - 1'b1 : ys[0];
  assign wall = nx[COORD_W-1] | ny[COORD_W-1] | (nx >= GX) | (ny >= GY);

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_pack
    assign x_values[i*COORD_W +: COORD_W] = xs[i];
    assign y_values[i*COORD_W +: COORD_W] = ys[i];
  end

  snake_collision_scanner #(.COORD_W(COORD_W), .LEN_W(LEN_W)) u_scan (
    .clk(clk), .reset(reset), .start(scan_start), .run(state == SCAN), .length(length),
    .head_x(xs[0]), .head_y(ys[0]), .slot_x(xs[idx]), .slot_y(ys[idx]),
    .idx(idx), .hit(hit), .done(done)
  );

  always_comb begin
    state_d = state;
    busy_d = busy;
    moved_d = 1'b0;
    done_d = game_done;
    latch = 1'b0;
    do_shift = 1'b0;
    scan_start = 1'b0;
    if (restart) begin
      state_d = IDLE;
      busy_d = 1'b0;
      done_d = 1'b0;
    end else case (state)
      IDLE: if (step) begin
        latch = 1'b1;
        state_d = wall ? DEAD : SHIFT;
        busy_d = !wall;
        done_d = wall;
      end
      SHIFT: begin
        do_shift = 1'b1;
        scan_start = 1'b1;
        state_d = SCAN;
      end
      SCAN: if (hit || done) begin
        state_d = hit ? DEAD : IDLE;
        busy_d = 1'b0;
        done_d = hit;
        moved_d = !hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      moved <= 1'b0;
      game_done <= 1'b0;
    end else begin
      state <= state_d;
      busy <= busy_d;
      moved <= moved_d;
      game_done <= done_d;
    end

  // the whole table shifts on one edge so the renderer never sees a torn frame
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        xs[i] <= init_x(i);
        ys[i] <= init_y(i);
      end
      length <= LEN_W'(INIT_LEN);
      heading <= DIR_RIGHT;
      cand_x <= '0;
      cand_y <= '0;
      grow_q <= 1'b0;
    end else if (restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        xs[i] <= init_x(i);
        ys[i] <= init_y(i);
      end
      length <= LEN_W'(INIT_LEN);
      heading <= DIR_RIGHT;
    end else begin
      if (latch) begin
        cand_x <= nx;
        cand_y <= ny;
        grow_q <= grow;
        heading <= eff;
      end
      if (do_shift) begin
        xs[0] <= cand_x;
        ys[0] <= cand_y;
        // slot[length] takes the old tail only when growing; at MAX_LEN no such slot exists
        for (int i = 1; i < MAX_LEN; i++)
          if (i < int'(length) || (i == int'(length) && grow_q)) begin
            xs[i] <= xs[i-1];
            ys[i] <= ys[i-1];
          end
        if (grow_q && int'(length) < MAX_LEN) length <= length + 1'b1;
      end
    end
endmodule

// File: tb/tb_snake_body_writer.sv
// tb_snake_body_writer: directed and random moves checked against a queue-based snake model
module tb_snake_body_writer;
  localparam int MAX_LEN = 100;
  logic clk = 1'b0, reset = 1'b0, step = 1'b0, grow = 1'b0, restart = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [MAX_LEN*32-1:0] x_values, y_values;
  logic [6:0] length;
  logic busy, moved, game_done;
  int tests = 0, fails = 0;
  int mx[$], my[$];
  int mhead;
  bit mdone;

  always #5 clk = ~clk;

  snake_body_writer dut (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .grow(grow), .restart(restart),
    .x_values(x_values), .y_values(y_values), .length(length), .busy(busy),
    .moved(moved), .game_done(game_done)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] sx(input int i);
    return $signed(x_values[32*i +: 32]);
  endfunction
  function automatic logic signed [63:0] sy(input int i);
    return $signed(y_values[32*i +: 32]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset;
    mx = {};
    my = {};
    for (int i = 0; i < 3; i++) begin
      mx.push_back(5 - i);
      my.push_back(5);
    end
    mhead = 1;
    mdone = 0;
  endfunction

  // kind: 0 clean move, 1 wall, 2 self hit; lat counts clock edges after the edge that takes step
  task automatic model_step(input int d, input int g, output int lat, output int kind);
    int eff, hx, hy;
    eff = ((d ^ 2) == mhead) ? mhead : d;
    mhead = eff;
    hx = mx[0] + (eff == 1 ? 1 : 0) - (eff == 3 ? 1 : 0);
    hy = my[0] + (eff == 2 ? 1 : 0) - (eff == 0 ? 1 : 0);
    if (hx < 0 || hx > 9 || hy < 0 || hy > 9) begin
      kind = 1;
      lat = 0;
      mdone = 1;
      return;
    end
    mx.push_front(hx);
    my.push_front(hy);
    if (!(g != 0 && mx.size() <= MAX_LEN)) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    kind = 0;
    lat = mx.size();
    for (int k = 1; k < mx.size(); k++)
      if (mx[k] == hx && my[k] == hy) begin
        kind = 2;
        lat = k + 1;
        mdone = 1;
        break;
      end
  endtask

  task automatic check_table(input string tag);
    int n, bad;
    n = mx.size();
    check({tag, "_len"}, length, n);
    for (int i = 0; i <= n && i < MAX_LEN; i++) begin
      check($sformatf("%s_x%0d", tag, i), sx(i), i < n ? mx[i] : -1);
      check($sformatf("%s_y%0d", tag, i), sy(i), i < n ? my[i] : -1);
    end
    bad = 0;
    for (int i = n + 1; i < MAX_LEN; i++)
      if (sx(i) !== -1 || sy(i) !== -1) bad++;
    check({tag, "_rest_empty_bad"}, bad, 0);
  endtask

  task automatic do_move(input int d, input int g, input bit inj);
    int lat, kind, n;
    model_step(d, g, lat, kind);
    dir = 2'(d);
    grow = g[0];
    step = 1'b1;
    tick;
    step = 1'b0;
    grow = 1'b0;
    n = 0;
    if (kind == 1) begin
      check("wall_done", game_done, 1);
    end else begin
      check("busy_on", busy, 1);
      while (!(moved || game_done) && n < lat + 5) begin
        if (inj && n < lat && $urandom_range(2) == 0) begin
          dir = 2'($urandom_range(3));
          grow = 1'($urandom_range(1));
          step = 1'b1;
        end
        tick;
        step = 1'b0;
        grow = 1'b0;
        n++;
      end
      check(kind == 0 ? "move_lat" : "hit_lat", n, lat);
      check("done_flag", game_done, kind == 2 ? 1 : 0);
      check("moved_flag", moved, kind == 0 ? 1 : 0);
      tick;
      check("moved_once", moved, 0);
    end
    check("busy_off", busy, 0);
    check_table("tbl");
  endtask

  task automatic restart_game;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    model_reset();
    check("rst_done", game_done, 0);
    check("rst_busy", busy, 0);
    check_table("rst");
  endtask

  task automatic dead_poke;
    dir = 2'($urandom_range(3));
    step = 1'b1;
    tick;
    step = 1'b0;
    repeat (4) begin
      tick;
      check("dead_moved", moved, 0);
    end
    check("dead_done", game_done, 1);
    check("dead_busy", busy, 0);
    check_table("dead");
  endtask

  task automatic abort_scan;
    restart_game();
    dir = 2'd1;
    grow = 1'($urandom_range(1));
    step = 1'b1;
    tick;
    step = 1'b0;
    grow = 1'b0;
    tick;
    check("abort_busy", busy, 1);
    restart = 1'b1;
    tick;
    restart = 1'b0;
    model_reset();
    repeat (5) begin
      check("abort_moved", moved, 0);
      tick;
    end
    check("abort_busy_off", busy, 0);
    check_table("abort");
  endtask

  // follows a Hamiltonian cycle of the 10x10 grid that already contains the initial body
  task automatic fill_grid;
    int cx[100], cy[100];
    int k, p, q, d, guard;
    k = 0;
    for (int x = 9; x >= 0; x--) begin cx[k] = x; cy[k] = 0; k++; end
    for (int y = 1; y < 10; y++)
      for (int j = 0; j < 9; j++) begin
        cx[k] = (y % 2 == 1) ? j : 8 - j;
        cy[k] = y;
        k++;
      end
    for (int y = 9; y >= 1; y--) begin cx[k] = 9; cy[k] = y; k++; end
    p = 0;
    for (int i = 0; i < 100; i++) if (cx[i] == 5 && cy[i] == 5) p = i;
    guard = 0;
    while ((mx.size() < MAX_LEN || guard < 100) && !mdone && guard < 110) begin
      q = (p + 1) % 100;
      d = cx[q] > cx[p] ? 1 : cx[q] < cx[p] ? 3 : cy[q] > cy[p] ? 2 : 0;
      do_move(d, 1, 0);
      p = q;
      guard++;
      if (mx.size() == MAX_LEN && guard >= 100) break;
    end
    check("t6_len", length, 100);
    check("t6_alive", game_done, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    check("t1_x0", sx(0), 5);
    check("t1_x1", sx(1), 4);
    check("t1_x2", sx(2), 3);
    check("t1_y0", sy(0), 5);
    check("t1_y2", sy(2), 5);
    check("t1_x3", sx(3), -1);
    check("t1_len", length, 3);
    check("t1_busy", busy, 0);
    check("t1_done", game_done, 0);
    check_table("t1");
    do_move(1, 0, 0);
    check("t2_hx", sx(0), 6);
    check("t2_tx", sx(2), 4);
    check("t2_x3", sx(3), -1);
    do_move(3, 0, 0);
    check("t3_hx", sx(0), 7);
    do_move(1, 1, 0);
    check("t3_len", length, 4);
    check("t3_x3", sx(3), 5);
    do_move(1, 0, 0);
    check("t4_hx", sx(0), 9);
    do_move(1, 0, 0);
    check("t4_done", game_done, 1);
    dead_poke();
    restart_game();
    do_move(1, 1, 0);
    do_move(1, 1, 0);
    do_move(0, 0, 0);
    do_move(3, 0, 0);
    do_move(2, 0, 0);
    check("t5_done", game_done, 1);
    abort_scan();
    restart_game();
    fill_grid();
    restart_game();
    for (int it = 0; it < 150; it++) begin
      if (mdone) restart_game();
      else if ($urandom_range(15) == 0) abort_scan();
      else do_move($urandom_range(3), $urandom_range(3) == 0 ? 1 : 0, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
